// File: rtl/alu_mdu_if.sv
// ============================================================================
// alu_mdu_if : request/response bundle between a requester and alu_mdu
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output start, op, a, b,
    input  busy, done, result, hi, lo, zero, overflow, illegal
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, hi, lo, zero, overflow, illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_mdu.sv
// ============================================================================
// alu_mdu : single-cycle ALU plus bit-serial unsigned multiply/divide unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_mdu_if.slave   bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MULTU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;

  logic [1:0]         state;
  logic [SHAMT_W-1:0] cnt;
  logic               is_div;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               zero_q;
  logic               overflow_q;
  logic               illegal_q;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_ill;
  logic               is_mdu_op;

  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    shamt   = bus.b[SHAMT_W-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = $signed(bus.a) >>> shamt;
      default: alu_res = '0;
    endcase
    alu_ill   = (bus.op > OP_DIVU);
    is_mdu_op = (bus.op == OP_MULTU) || (bus.op == OP_DIVU);
  end

  // One iteration of shift-add multiply or restoring divide. Both share
  // acc_hi (partial product / remainder) and acc_lo (multiplier / quotient).
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand});
    div_sub   = div_shift[WIDTH-1:0] - mcand;
    if (is_div) begin
      nxt_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      is_div     <= 1'b0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      mcand      <= '0;
      result_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (is_mdu_op) begin
              state  <= S_CALC;
              cnt    <= '0;
              is_div <= (bus.op == OP_DIVU);
              acc_hi <= '0;
              acc_lo <= (bus.op == OP_DIVU) ? bus.a : bus.b;
              mcand  <= (bus.op == OP_DIVU) ? bus.b : bus.a;
            end else begin
              state      <= S_DONE;
              result_q   <= alu_res;
              zero_q     <= (alu_res == '0);
              overflow_q <= alu_ovf;
              illegal_q  <= alu_ill;
            end
          end
        end
        S_CALC: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == SHAMT_W'(WIDTH-1)) begin
            state      <= S_DONE;
            hi_q       <= nxt_hi;
            lo_q       <= nxt_lo;
            result_q   <= nxt_lo;
            zero_q     <= (nxt_lo == '0);
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.result   = result_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = overflow_q;
  assign bus.illegal  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
// tb_alu_mdu : scoreboard bench for alu_mdu at WIDTH=32 and WIDTH=8
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mdu;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mdu_if #(.WIDTH(32)) b32 ();
  alu_mdu_if #(.WIDTH(8))  b8 ();

  alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  alu_mdu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

  typedef struct {
    int          tag;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
    logic        ov;
    logic        il;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  logic [31:0] m32_hi = '0, m32_lo = '0;
  logic [31:0] m8_hi = '0,  m8_lo = '0;

  task automatic chk(input string nm, input int tag, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", nm, tag, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b32.done === 1'b1) begin
      if (q32.size() == 0) chk("w32_spurious_done", -1, 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        chk("w32_result",   e.tag, b32.result,   e.res);
        chk("w32_hi",       e.tag, b32.hi,       e.hi);
        chk("w32_lo",       e.tag, b32.lo,       e.lo);
        chk("w32_zero",     e.tag, b32.zero,     e.z);
        chk("w32_overflow", e.tag, b32.overflow, e.ov);
        chk("w32_illegal",  e.tag, b32.illegal,  e.il);
        chk("w32_latency",  e.tag, cyc - e.acc,  e.lat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b8.done === 1'b1) begin
      if (q8.size() == 0) chk("w8_spurious_done", -1, 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        chk("w8_result",   e.tag, b8.result,   e.res);
        chk("w8_hi",       e.tag, b8.hi,       e.hi);
        chk("w8_lo",       e.tag, b8.lo,       e.lo);
        chk("w8_zero",     e.tag, b8.zero,     e.z);
        chk("w8_overflow", e.tag, b8.overflow, e.ov);
        chk("w8_illegal",  e.tag, b8.illegal,  e.il);
        chk("w8_latency",  e.tag, cyc - e.acc, e.lat);
      end
    end
  end

  // Issue one request; expected response goes to the scoreboard before the accepting edge.
  task automatic issue(input bit w8, input int tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [31:0] eh, input logic [31:0] el,
                       input logic ez, input logic eo, input logic ei, input bit mdu);
    exp_t e;
    @(negedge clk);
    e.tag = tag; e.res = er; e.z = ez; e.ov = eo; e.il = ei; e.acc = cyc;
    if (w8) begin
      if (mdu) begin m8_hi = eh; m8_lo = el; end
      e.hi = m8_hi; e.lo = m8_lo; e.lat = mdu ? 9 : 1;
      q8.push_back(e);
      b8.op = op; b8.a = a[7:0]; b8.b = b[7:0]; b8.start = 1'b1;
      @(negedge clk);
      b8.start = 1'b0;
    end else begin
      if (mdu) begin m32_hi = eh; m32_lo = el; end
      e.hi = m32_hi; e.lo = m32_lo; e.lat = mdu ? 33 : 1;
      q32.push_back(e);
      b32.op = op; b32.a = a; b32.b = b; b32.start = 1'b1;
      @(negedge clk);
      b32.start = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit w8);
    for (int i = 0; i < 200; i++) begin
      if (w8 ? !b8.busy : !b32.busy) return;
      @(negedge clk);
    end
    chk(w8 ? "w8_idle_timeout" : "w32_idle_timeout", -1, 64'd1, 64'd0);
  endtask

  task automatic alu(input bit w8, input int tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic eo, input logic ei);
    issue(w8, tag, op, a, b, er, 32'd0, 32'd0, (er == 32'd0), eo, ei, 1'b0);
    wait_idle(w8);
  endtask

  task automatic mdu(input bit w8, input int tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    issue(w8, tag, op, a, b, el, eh, el, (el == 32'd0), 1'b0, 1'b0, 1'b1);
    wait_idle(w8);
  endtask

  task automatic chk_reset_state(input int tag);
    chk("rst_busy",     tag, b32.busy,     0);
    chk("rst_done",     tag, b32.done,     0);
    chk("rst_result",   tag, b32.result,   0);
    chk("rst_hi",       tag, b32.hi,       0);
    chk("rst_lo",       tag, b32.lo,       0);
    chk("rst_zero",     tag, b32.zero,     0);
    chk("rst_overflow", tag, b32.overflow, 0);
    chk("rst_illegal",  tag, b32.illegal,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog vec=-1 actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy;
    reset = 1'b1;
    b32.start = 0; b32.op = 0; b32.a = 0; b32.b = 0;
    b8.start = 0;  b8.op = 0;  b8.a = 0;  b8.b = 0;
    repeat (2) @(negedge clk);
    chk_reset_state(0);
    chk("rst8_busy", 0, b8.busy, 0);
    chk("rst8_result", 0, b8.result, 0);
    reset = 1'b0;

    alu(0, 1,  4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 0);
    alu(0, 2,  4'd1,  32'd5,        32'd5,        32'h0,        0, 0);
    alu(0, 3,  4'd10, 32'h80000000, 32'd4,        32'hF8000000, 0, 0);
    alu(0, 4,  4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0);
    alu(0, 5,  4'd3,  32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 0, 0);
    alu(0, 6,  4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 0, 0);
    alu(0, 7,  4'd5,  32'h0,        32'h0,        32'hFFFFFFFF, 0, 0);
    alu(0, 8,  4'd5,  32'hFFFFFFFF, 32'h0,        32'h0,        0, 0);
    alu(0, 9,  4'd6,  32'hFFFFFFFF, 32'h1,        32'h1,        0, 0);
    alu(0, 10, 4'd7,  32'hFFFFFFFF, 32'h1,        32'h0,        0, 0);
    alu(0, 11, 4'd8,  32'h1,        32'h25,       32'h20,       0, 0);
    alu(0, 12, 4'd9,  32'h80000000, 32'd31,       32'h1,        0, 0);
    alu(0, 13, 4'd1,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1, 0);
    alu(0, 14, 4'd0,  32'h80000000, 32'h80000000, 32'h0,        1, 0);

    // MULTU with start pulses and operand churn while busy
    issue(0, 15, 4'd11, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE, 0, 0, 0, 1);
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      if (!b32.busy) break;
      nbusy++;
      b32.a = 32'h12345678 + i;
      b32.b = 32'h9ABC0000 + i;
      b32.op = 4'd0;
      b32.start = (i == 3 || i == 10 || i == 31);
      @(negedge clk);
    end
    b32.start = 1'b0;
    chk("w32_busy_cycles", 15, nbusy, 33);

    alu(0, 16, 4'd0,  32'd1, 32'd1, 32'd2, 0, 0);
    mdu(0, 17, 4'd12, 32'd100, 32'd7, 32'd2, 32'd14);
    mdu(0, 18, 4'd12, 32'd9,   32'd0, 32'd9, 32'hFFFFFFFF);
    alu(0, 19, 4'd13, 32'd3, 32'd4, 32'd0, 0, 1);

    // reset in the middle of a MULTU
    issue(0, 20, 4'd11, 32'd3, 32'd4, 32'd12, 32'd0, 32'd12, 0, 0, 0, 1);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    q32.delete();
    m32_hi = '0; m32_lo = '0;
    #1 chk_reset_state(20);
    @(negedge clk);
    reset = 1'b0;
    alu(0, 21, 4'd0, 32'd2, 32'd3, 32'd5, 0, 0);

    mdu(1, 30, 4'd11, 32'hFF, 32'hFF, 32'hFE, 32'h01);
    alu(1, 31, 4'd14, 32'h12, 32'h34, 32'h0, 0, 1);
    alu(1, 32, 4'd0,  32'h7F, 32'h01, 32'h80, 1, 0);
    mdu(1, 33, 4'd12, 32'hC8, 32'h0D, 32'h05, 32'h0F);

    repeat (3) @(negedge clk);
    chk("queue_empty", -1, q32.size() + q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; SHALL be a power of two, at least 4.
REQ-002 Derived SHAMT_W = log2(WIDTH): shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request; accepted only in IDLE.
REQ-006 op  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MULTU, 12 DIVU, 13-15 illegal.
REQ-007 a, b  input  WIDTH each  operands; sampled only on the accepting edge.
REQ-008 busy  output  1  high in CALC and DONE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  WIDTH  primary result.
REQ-011 hi, lo  output  WIDTH each  MULTU product halves / DIVU remainder, quotient.
REQ-012 zero  output  1  result == 0.
REQ-013 overflow  output  1  signed overflow, ADD/SUB only.
REQ-014 illegal  output  1  op code 13-15 was accepted.

Function
REQ-015 FSM SHALL have states IDLE, CALC and DONE.
REQ-016 IDLE & start & op not in {11,12} -> DONE; the registered result is visible in the cycle after the accepting edge.
REQ-017 IDLE & start & op in {11,12} -> CALC with iteration counter = 0; operands latched on that edge.
REQ-018 CALC SHALL process one bit per cycle and, after WIDTH iterations, go to DONE; done is high WIDTH+1 cycles after the accepting edge.
REQ-019 DONE SHALL assert done for exactly one cycle, then go to IDLE unconditionally.
REQ-020 start SHALL be ignored in CALC and DONE; operands changing after acceptance SHALL NOT affect the result.
REQ-021 result, hi, lo, zero, overflow and illegal SHALL hold until the next completion.
REQ-022 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow = operand signs agree (for SUB, sign of a differs from sign of b) and the result sign differs.
REQ-023 SLT SHALL compare signed, SLTU unsigned; result = 1 or 0.
REQ-024 SLL/SRL/SRA SHALL shift a by b[SHAMT_W-1:0]; SRA sign-fills.
REQ-025 MULTU SHALL use unsigned shift-add: {hi,lo} = a*b (2*WIDTH bits); result = lo.
REQ-026 DIVU SHALL use unsigned restoring division: lo = quotient, hi = remainder, result = lo.
REQ-027 DIVU with b = 0 SHALL give lo = all ones, hi = a, same latency, no extra flag.
REQ-028 Non-MDU ops SHALL leave hi/lo unchanged.
REQ-029 Illegal op SHALL take the single-cycle path: result = 0, illegal = 1, zero = 1.
REQ-030 zero SHALL be computed from the final result for every op.

Reset
REQ-031 reset asserted SHALL immediately force IDLE, counter 0, and busy, done, result, hi, lo, zero, overflow, illegal all to 0.
REQ-032 reset mid-CALC SHALL abort with no done pulse; the first start after release is accepted normally.

Verification
REQ-033 WIDTH=32, ADD a=0x7FFFFFFF, b=1 -> next cycle done=1, result=0x80000000, overflow=1, zero=0.
REQ-034 SUB a=5, b=5 -> result=0, zero=1, overflow=0; SRA a=0x80000000, b=4 -> result=0xF8000000.
REQ-035 MULTU a=0xFFFFFFFF, b=2 -> busy for 33 cycles, done at cycle 33, hi=1, lo=0xFFFFFFFE; start pulses while busy are ignored.
REQ-036 DIVU a=100, b=7 -> lo=14, hi=2; DIVU a=9, b=0 -> lo=0xFFFFFFFF, hi=9.
REQ-037 Reset asserted at cycle 10 of MULTU -> busy=0 immediately, no done; a following ADD 2+3 -> result=5.
REQ-038 WIDTH=8 build, MULTU 0xFF*0xFF -> done at cycle 9, hi=0xFE, lo=0x01; op=14 -> illegal=1, result=0.
